btn_reader: RTL and testbench

BTN_READER -- requirements
Module: btn_reader

---
 rtl/btn_pkg.sv | 15 +
 rtl/sync2.sv | 23 ++
 rtl/btn_reader.sv | 130 +++++++++++++
 tb/tb_btn_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and widths for the pushbutton reader and related input blocks.
package btn_pkg;

    localparam int unsigned DEBOUNCE_W = 24;
    localparam int unsigned LONG_W     = 27;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_reader.sv
// Debounced pushbutton reader with press/release strobes and press counter.
// Long-press detection is built only when BTN_READER_LONG_PRESS_EN is defined.
import btn_pkg::*;

module btn_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             btn_n,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_cnt
);

`ifdef BTN_READER_LONG_PRESS_EN
    localparam int unsigned SH_W = LONG_W;
    localparam logic [SH_W-1:0] LONG_LAST = SH_W'(LONG_CYCLES - 1);
`else
    localparam int unsigned SH_W = DEBOUNCE_W;
`endif
    localparam logic [SH_W-1:0]       DEB_LAST = SH_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_W-1:0] REL_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t            state;
    logic [SH_W-1:0]       cnt;
    logic [SH_W-1:0]       cnt_inc;
    logic [DEBOUNCE_W-1:0] rel_cnt;
    logic [DEBOUNCE_W-1:0] rel_inc;
    logic                  btn_s;
    logic                  pressed_s;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (btn_s)
    );

    assign pressed_s = ~btn_s;

    always_comb begin
        cnt_inc = cnt + SH_W'(1);
        rel_inc = rel_cnt + DEBOUNCE_W'(1);
    end

`ifdef BTN_READER_LONG_PRESS_EN
    logic long_done;
`else
    assign long_pulse = 1'b0;
`endif

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rel_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_cnt     <= '0;
`ifdef BTN_READER_LONG_PRESS_EN
            long_pulse    <= 1'b0;
            long_done     <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_READER_LONG_PRESS_EN
            long_pulse    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pressed_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= IDLE;
                    end else if (cnt_inc == DEB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        press_cnt   <= press_cnt + CNT_W'(1);
`ifdef BTN_READER_LONG_PRESS_EN
                        long_done   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
`ifdef BTN_READER_LONG_PRESS_EN
                    // Fires the cycle after the count lands on the last value;
                    // long_done keeps a bounce back into PRESSED from refiring.
                    if (cnt != LONG_LAST) begin
                        cnt <= cnt_inc;
                    end else if (!long_done) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
`endif
                    if (!pressed_s) begin
                        state   <= RELEASE_WAIT;
                        rel_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state <= PRESSED;
                    end else if (rel_inc == REL_LAST) begin
                        state         <= IDLE;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        rel_cnt <= rel_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_reader.sv
// Directed self-checking bench for btn_reader (DEBOUNCE_CYCLES=8, LONG_CYCLES=40).
module tb_btn_reader;

    localparam int unsigned D = 8;
    localparam int unsigned L = 40;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_n   = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int n_press     = 0;
    int n_release   = 0;
    int n_long      = 0;
    int n_excl      = 0;

    btn_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk_50m       (clk_50m),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_cnt     (press_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        n_press   <= n_press + int'(press_pulse);
        n_release <= n_release + int'(release_pulse);
        n_long    <= n_long + int'(long_pulse);
        if ($countones({press_pulse, release_pulse, long_pulse}) > 1)
            n_excl <= n_excl + 1;
    end

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) step();
        vectors++; if (btn_level !== 1'b0) begin miscompares++; $display("FAIL reset_level: got %b expected 0", btn_level); end
        vectors++; if (press_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_press: got %b expected 0", press_pulse); end
        vectors++; if (release_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_release: got %b expected 0", release_pulse); end
        vectors++; if (long_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_long: got %b expected 0", long_pulse); end
        vectors++; if (press_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", press_cnt); end
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int p0;
        int lvl_seen;
        p0 = n_press;
        lvl_seen = 0;
        btn_n = 1'b0;
        repeat (5) step();
        btn_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (btn_level) lvl_seen++;
        end
        vectors++; if (n_press - p0 !== 0) begin miscompares++; $display("FAIL glitch_press: got %0d pulses expected 0", n_press - p0); end
        vectors++; if (lvl_seen !== 0) begin miscompares++; $display("FAIL glitch_level: got %0d high cycles expected 0", lvl_seen); end
        vectors++; if (press_cnt !== 8'd0) begin miscompares++; $display("FAIL glitch_cnt: got %0d expected 0", press_cnt); end
    endtask

    task automatic test_press();
        int first;
        int npulse;
        first = 0; npulse = 0;
        btn_n = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (press_pulse) begin npulse++; if (first == 0) first = k; end
        end
        vectors++; if (first !== 10) begin miscompares++; $display("FAIL press_edge: got %0d expected 10", first); end
        vectors++; if (npulse !== 1) begin miscompares++; $display("FAIL press_width: got %0d expected 1", npulse); end
        vectors++; if (btn_level !== 1'b1) begin miscompares++; $display("FAIL press_level: got %b expected 1", btn_level); end
        vectors++; if (press_cnt !== 8'd1) begin miscompares++; $display("FAIL press_cnt: got %0d expected 1", press_cnt); end
        first = 0; npulse = 0;
        btn_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (release_pulse) begin npulse++; if (first == 0) first = k; end
        end
        vectors++; if (first !== 10) begin miscompares++; $display("FAIL release_edge: got %0d expected 10", first); end
        vectors++; if (npulse !== 1) begin miscompares++; $display("FAIL release_width: got %0d expected 1", npulse); end
        vectors++; if (btn_level !== 1'b0) begin miscompares++; $display("FAIL release_level: got %b expected 0", btn_level); end
    endtask

    task automatic test_bounce();
        int p0;
        int r0;
        int first;
        btn_n = 1'b0;
        repeat (14) step();
        p0 = n_press; r0 = n_release;
        btn_n = 1'b1;
        repeat (3) step();
        btn_n = 1'b0;
        repeat (15) step();
        vectors++; if (n_release - r0 !== 0) begin miscompares++; $display("FAIL bounce_release: got %0d expected 0", n_release - r0); end
        vectors++; if (n_press - p0 !== 0) begin miscompares++; $display("FAIL bounce_press: got %0d expected 0", n_press - p0); end
        vectors++; if (btn_level !== 1'b1) begin miscompares++; $display("FAIL bounce_level: got %b expected 1", btn_level); end
        first = 0;
        btn_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (release_pulse && first == 0) first = k;
        end
        vectors++; if (first !== 10) begin miscompares++; $display("FAIL bounce_release_edge: got %0d expected 10", first); end
        vectors++; if (press_cnt !== 8'd2) begin miscompares++; $display("FAIL bounce_cnt: got %0d expected 2", press_cnt); end
    endtask

    task automatic test_long();
        int pk;
        int lk;
        int nlong;
        int first;
        pk = 0; lk = 0; nlong = 0;
        btn_n = 1'b0;
        for (int k = 1; k <= 74; k++) begin
            if (k == 61) btn_n = 1'b1;
            step();
            if (press_pulse && pk == 0) pk = k;
            if (long_pulse) begin nlong++; if (lk == 0) lk = k; end
            if (release_pulse && k > 60) first = k - 60;
        end
`ifdef BTN_READER_LONG_PRESS_EN
        vectors++; if (nlong !== 1) begin miscompares++; $display("FAIL long_count: got %0d expected 1", nlong); end
        vectors++; if (lk - pk !== 40) begin miscompares++; $display("FAIL long_delay: got %0d expected 40", lk - pk); end
`else
        vectors++; if (nlong !== 0) begin miscompares++; $display("FAIL long_count: got %0d expected 0", nlong); end
        vectors++; if (lk !== 0) begin miscompares++; $display("FAIL long_edge: got %0d expected 0", lk); end
`endif
        vectors++; if (first !== 10) begin miscompares++; $display("FAIL long_release_edge: got %0d expected 10", first); end
        vectors++; if (press_cnt !== 8'd3) begin miscompares++; $display("FAIL long_cnt: got %0d expected 3", press_cnt); end
    endtask

    task automatic test_wrap();
        int p0;
        int r0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        p0 = n_press; r0 = n_release;
        for (int i = 0; i < 256; i++) begin
            btn_n = 1'b0;
            repeat (12) step();
            btn_n = 1'b1;
            repeat (12) step();
            if (i == 254) begin
                vectors++; if (press_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d expected 255", press_cnt); end
            end
        end
        vectors++; if (press_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_cnt: got %0d expected 0", press_cnt); end
        vectors++; if (n_release - r0 !== 256) begin miscompares++; $display("FAIL wrap_releases: got %0d expected 256", n_release - r0); end
        vectors++; if (n_press - p0 !== 256) begin miscompares++; $display("FAIL wrap_presses: got %0d expected 256", n_press - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        int r0;
        int first;
        btn_n = 1'b0;
        repeat (14) step();
        vectors++; if (btn_level !== 1'b1) begin miscompares++; $display("FAIL mid_pre_level: got %b expected 1", btn_level); end
        rst_n = 1'b0;
        #1;
        vectors++; if (btn_level !== 1'b0) begin miscompares++; $display("FAIL mid_level: got %b expected 0", btn_level); end
        vectors++; if (press_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_cnt: got %0d expected 0", press_cnt); end
        vectors++; if ({press_pulse, release_pulse, long_pulse} !== 3'b000) begin miscompares++; $display("FAIL mid_pulses: got %b expected 000", {press_pulse, release_pulse, long_pulse}); end
        p0 = n_press; r0 = n_release;
        repeat (3) step();
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (press_pulse && first == 0) first = k;
        end
        vectors++; if (first !== 10) begin miscompares++; $display("FAIL mid_press_edge: got %0d expected 10", first); end
        vectors++; if (press_cnt !== 8'd1) begin miscompares++; $display("FAIL mid_press_cnt: got %0d expected 1", press_cnt); end
        vectors++; if (n_press - p0 !== 1) begin miscompares++; $display("FAIL mid_press_count: got %0d expected 1", n_press - p0); end
        vectors++; if (n_release - r0 !== 0) begin miscompares++; $display("FAIL mid_release_count: got %0d expected 0", n_release - r0); end
        btn_n = 1'b1;
        repeat (14) step();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_bounce();
        test_long();
        test_wrap();
        test_reset_mid();
        vectors++; if (n_excl !== 0) begin miscompares++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_excl); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
